// File: rtl/trafficlight_xing.sv
// Two-approach intersection controller: protected-left/green/yellow/all-red cycle,
// emergency preemption with phase save/restore, and flashing-yellow maintenance mode.
module trafficlight_xing #(
    parameter int LEFT_CYC    = 5,
    parameter int GREEN_CYC   = 10,
    parameter int YELLOW_CYC  = 3,
    parameter int CLEAR_CYC   = 2,
    parameter int PREEMPT_CYC = 1,
    parameter int FLASH_CYC   = 4,
    parameter int CW          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emergency,
    input  logic       flash,
    output logic [3:0] out_ns,
    output logic [3:0] out_ew,
    output logic       preempt,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        NS_LEFT   = 4'd0,
        NS_GREEN  = 4'd1,
        NS_YELLOW = 4'd2,
        CLR_A     = 4'd3,
        EW_LEFT   = 4'd4,
        EW_GREEN  = 4'd5,
        EW_YELLOW = 4'd6,
        CLR_B     = 4'd7,
        PREEMPT   = 4'd8,
        FLASH     = 4'd9
    } state_t;

    localparam logic [CW-1:0] D_LEFT   = CW'(LEFT_CYC - 1);
    localparam logic [CW-1:0] D_GREEN  = CW'(GREEN_CYC - 1);
    localparam logic [CW-1:0] D_YELLOW = CW'(YELLOW_CYC - 1);
    localparam logic [CW-1:0] D_CLEAR  = CW'(CLEAR_CYC - 1);
    localparam logic [CW-1:0] D_PRE    = CW'(PREEMPT_CYC - 1);
    localparam logic [CW-1:0] D_FLASH  = CW'(FLASH_CYC - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state, state_nx;
    state_t        saved_state, saved_state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] saved_cnt, saved_cnt_nx;
    logic          flash_on, flash_on_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= NS_LEFT;
            cnt         <= D_LEFT;
            saved_state <= NS_LEFT;
            saved_cnt   <= '0;
            flash_on    <= 1'b1;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            saved_state <= saved_state_nx;
            saved_cnt   <= saved_cnt_nx;
            flash_on    <= flash_on_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        saved_state_nx = saved_state;
        saved_cnt_nx   = saved_cnt;
        flash_on_nx    = flash_on;
        if (emergency && state != PREEMPT) begin
            // The interrupted cycle is not credited: the raw counter is saved.
            saved_state_nx = state;
            saved_cnt_nx   = cnt;
            state_nx       = PREEMPT;
            cnt_nx         = D_PRE;
        end else if (state == PREEMPT) begin
            if (emergency || cnt != '0) begin
                if (cnt != '0) cnt_nx = cnt - ONE;
            end else if (saved_state == FLASH) begin
                state_nx    = FLASH;
                cnt_nx      = D_FLASH;
                flash_on_nx = 1'b1;
            end else begin
                state_nx = saved_state;
                cnt_nx   = saved_cnt;
            end
        end else if (flash && state != FLASH) begin
            state_nx    = FLASH;
            cnt_nx      = D_FLASH;
            flash_on_nx = 1'b1;
        end else if (state == FLASH) begin
            if (!flash) begin
                state_nx = CLR_B;
                cnt_nx   = D_CLEAR;
            end else if (cnt == '0) begin
                cnt_nx      = D_FLASH;
                flash_on_nx = ~flash_on;
            end else begin
                cnt_nx = cnt - ONE;
            end
        end else if (cnt == '0) begin
            case (state)
                NS_LEFT:   begin state_nx = NS_GREEN;  cnt_nx = D_GREEN;  end
                NS_GREEN:  begin state_nx = NS_YELLOW; cnt_nx = D_YELLOW; end
                NS_YELLOW: begin state_nx = CLR_A;     cnt_nx = D_CLEAR;  end
                CLR_A:     begin state_nx = EW_LEFT;   cnt_nx = D_LEFT;   end
                EW_LEFT:   begin state_nx = EW_GREEN;  cnt_nx = D_GREEN;  end
                EW_GREEN:  begin state_nx = EW_YELLOW; cnt_nx = D_YELLOW; end
                EW_YELLOW: begin state_nx = CLR_B;     cnt_nx = D_CLEAR;  end
                default:   begin state_nx = NS_LEFT;   cnt_nx = D_LEFT;   end
            endcase
        end else begin
            cnt_nx = cnt - ONE;
        end
    end

    always_comb begin
        out_ns = 4'b0001;
        out_ew = 4'b0001;
        case (state)
            NS_LEFT:   out_ns = 4'b1001;
            NS_GREEN:  out_ns = 4'b0100;
            NS_YELLOW: out_ns = 4'b0010;
            EW_LEFT:   out_ew = 4'b1001;
            EW_GREEN:  out_ew = 4'b0100;
            EW_YELLOW: out_ew = 4'b0010;
            FLASH: begin
                out_ns = flash_on ? 4'b0010 : 4'b0000;
                out_ew = flash_on ? 4'b0010 : 4'b0000;
            end
            default: ;
        endcase
    end

    assign preempt = (state == PREEMPT);
    assign phase   = state;

endmodule

// File: tb/tb_trafficlight_xing.sv
// Scoreboard bench for trafficlight_xing: directed scenarios plus random
// emergency/flash traffic, checked against a remaining-cycles reference model.
module tb_trafficlight_xing;

    localparam int LEFT_CYC    = 5;
    localparam int GREEN_CYC   = 10;
    localparam int YELLOW_CYC  = 3;
    localparam int CLEAR_CYC   = 2;
    localparam int PREEMPT_CYC = 1;
    localparam int FLASH_CYC   = 4;
    localparam int CW          = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       emergency;
    logic       flash;
    logic [3:0] out_ns;
    logic [3:0] out_ew;
    logic       preempt;
    logic [3:0] phase;

    trafficlight_xing #(
        .LEFT_CYC   (LEFT_CYC),
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC),
        .CLEAR_CYC  (CLEAR_CYC),
        .PREEMPT_CYC(PREEMPT_CYC),
        .FLASH_CYC  (FLASH_CYC),
        .CW         (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .emergency(emergency),
        .flash    (flash),
        .out_ns   (out_ns),
        .out_ew   (out_ew),
        .preempt  (preempt),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ph;
        logic [3:0] ns;
        logic [3:0] ew;
        logic       pre;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: phase index 0..9, cycles remaining in a timed phase
    // (including the current one), cycles elapsed in FLASH/PREEMPT, saved context.
    int m_phase, m_rem, m_el, m_sv_phase, m_sv_rem;

    function automatic int dur(input int p);
        case (p % 4)
            0:       return LEFT_CYC;
            1:       return GREEN_CYC;
            2:       return YELLOW_CYC;
            default: return CLEAR_CYC;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_rem = LEFT_CYC; m_el = 0; m_sv_phase = 0; m_sv_rem = 0;
    endtask

    task automatic model_step(input logic e, input logic f);
        if (e && m_phase != 8) begin
            m_sv_phase = m_phase; m_sv_rem = m_rem; m_phase = 8; m_el = 1;
        end else if (m_phase == 8) begin
            if (!e && m_el >= PREEMPT_CYC) begin
                if (m_sv_phase == 9) begin m_phase = 9; m_el = 1; end
                else begin m_phase = m_sv_phase; m_rem = m_sv_rem; end
            end else m_el++;
        end else if (f && m_phase != 9) begin
            m_phase = 9; m_el = 1;
        end else if (m_phase == 9) begin
            if (!f) begin m_phase = 7; m_rem = CLEAR_CYC; end
            else m_el++;
        end else if (m_rem == 1) begin
            m_phase = (m_phase + 1) % 8; m_rem = dur(m_phase);
        end else m_rem--;
    endtask

    task automatic push_exp();
        exp_t x;
        logic [3:0] lamp;
        x.ph = 4'(m_phase); x.ns = 4'b0001; x.ew = 4'b0001; x.pre = (m_phase == 8);
        if (m_phase == 9) begin
            lamp = ((((m_el - 1) / FLASH_CYC) % 2) == 0) ? 4'b0010 : 4'b0000;
            x.ns = lamp; x.ew = lamp;
        end else if (m_phase < 8 && (m_phase % 4) != 3) begin
            lamp = ((m_phase % 4) == 0) ? 4'b1001 : ((m_phase % 4) == 1) ? 4'b0100 : 4'b0010;
            if (m_phase < 4) x.ns = lamp; else x.ew = lamp;
        end
        expq.push_back(x);
    endtask

    task automatic drive(input logic e, input logic f);
        @(negedge clk); #1;
        emergency = e; flash = f;
        @(posedge clk);
        if (rst_n) model_step(e, f); else model_reset();
        push_exp();
    endtask

    task automatic wait_model(input int p, input int r, input string name);
        int n;
        n = 0;
        while (!(m_phase == p && m_rem == r) && n < 100) begin
            drive(1'b0, 1'b0);
            n++;
        end
        if (!(m_phase == p && m_rem == r)) begin
            checks++; failures++;
            $display("FAIL wait_%s: timed out at phase=%0d rem=%0d, required phase=%0d rem=%0d",
                     name, m_phase, m_rem, p, r);
        end
    endtask

    task automatic async_reset_mid_preempt();
        drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        #1 rst_n = 1'b0; emergency = 1'b0;
        #1 checks++;
        if (out_ns !== 4'b1001 || out_ew !== 4'b0001 || preempt !== 1'b0 || phase !== 4'd0) begin
            failures++;
            $display("FAIL async_reset: ns=%b ew=%b preempt=%b phase=%0d, required ns=1001 ew=0001 preempt=0 phase=0",
                     out_ns, out_ew, preempt, phase);
        end
        #2 rst_n = 1'b1;
        expq.delete();
        model_reset();
        push_exp();
    endtask

    // Monitor: outputs are presented every cycle; sample mid-cycle on the falling edge.
    exp_t got_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                got_exp = expq.pop_front();
                checks++;
                if (phase !== got_exp.ph || out_ns !== got_exp.ns || out_ew !== got_exp.ew ||
                    preempt !== got_exp.pre) begin
                    failures++;
                    $display("FAIL scoreboard @%0t: phase=%0d ns=%b ew=%b preempt=%b, expected phase=%0d ns=%b ew=%b preempt=%b",
                             $time, phase, out_ns, out_ew, preempt,
                             got_exp.ph, got_exp.ns, got_exp.ew, got_exp.pre);
                end
                checks++;
                if ((out_ns[3] | out_ns[2]) && (out_ew[3] | out_ew[2])) begin
                    failures++;
                    $display("FAIL conflict @%0t: ns=%b ew=%b, required no green/left on both",
                             $time, out_ns, out_ew);
                end
            end
        end
    end

    int e_hold, f_hold;
    logic re, rf;

    initial begin
        rst_n = 1'b0; emergency = 1'b0; flash = 1'b0;
        model_reset();
        repeat (3) drive(1'b0, 1'b0);
        #2 rst_n = 1'b1;

        // Free run: two full 40-cycle rotations.
        repeat (80) drive(1'b0, 1'b0);

        // One-cycle emergency at NS_GREEN's 4th cycle.
        wait_model(1, GREEN_CYC - 3, "ns_green4");
        drive(1'b1, 1'b0);
        repeat (12) drive(1'b0, 1'b0);

        // Emergency held 6 cycles during EW_YELLOW with counter 1.
        wait_model(6, 2, "ew_yellow");
        repeat (6) drive(1'b1, 1'b0);
        repeat (6) drive(1'b0, 1'b0);

        // Flash held 20 cycles from NS_GREEN entry.
        wait_model(1, GREEN_CYC, "ns_green_entry");
        repeat (20) drive(1'b0, 1'b1);
        repeat (8) drive(1'b0, 1'b0);

        // Emergency and flash together, then flash alone, then neither.
        wait_model(5, 6, "ew_green");
        repeat (3) drive(1'b1, 1'b1);
        repeat (6) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b0);

        // Emergency on the final cycle of a phase.
        wait_model(2, 1, "ns_yellow_last");
        drive(1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0);

        // Asynchronous reset during PREEMPT; NS_LEFT must then run its full length.
        wait_model(4, 3, "ew_left");
        async_reset_mid_preempt();
        repeat (12) drive(1'b0, 1'b0);

        // Randomized emergency and flash episodes.
        e_hold = 0; f_hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (e_hold == 0 && $urandom_range(0, 39) == 0) e_hold = $urandom_range(1, 8);
            if (f_hold == 0 && $urandom_range(0, 59) == 0) f_hold = $urandom_range(1, 30);
            re = (e_hold > 0);
            rf = (f_hold > 0);
            if (e_hold > 0) e_hold--;
            if (f_hold > 0) f_hold--;
            drive(re, rf);
        end
        repeat (3) drive(1'b0, 1'b0);

        repeat (2) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
